// File: rtl/intc_apb.sv
// APB interrupt controller: per-source level/rising-edge pending latch, enable mask,
// lowest-index-first priority vector and registered CPU interrupt.
module intc_apb #(
  parameter int NUM_IRQ = 8,
  parameter int SYNC    = 1
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic [31:0]        PADDR,
  input  logic               PWRITE,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o,
  output logic               irqb_o,
  output logic [5:0]         vector_o
);

  localparam logic [2:0] REG_RAW = 3'd0, REG_EN = 3'd1, REG_MODE = 3'd2,
                         REG_PEND = 3'd3, REG_VEC = 3'd4, REG_SET = 3'd5;

  logic [NUM_IRQ-1:0] s, rise, active, wdat;
  logic [NUM_IRQ-1:0] prev_q, enable_q, enable_d, mode_q, mode_d, pending_q, pending_d;
  logic               irq_q, irq_d;
  logic [5:0]         vector_q, vector_d;
  logic               wr;
  logic [2:0]         sel;
  logic               unused_bits;

  assign wr          = PSEL & PENABLE & PWRITE & PRESETn;
  assign sel         = PADDR[4:2];
  assign wdat        = PWDATA[NUM_IRQ-1:0];
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

  generate
    if (SYNC != 0) begin : g_sync
      logic [NUM_IRQ-1:0] sync1_q, sync2_q;
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= irq_i;
          sync2_q <= sync1_q;
        end
      end
      assign s = sync2_q;
    end else begin : g_nosync
      assign s = irq_i;
    end
  endgenerate

  assign rise   = s & ~prev_q;
  assign active = pending_q & enable_q;

  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    vector_d  = '0;
    if (wr && sel == REG_EN)   enable_d = wdat;
    if (wr && sel == REG_MODE) mode_d   = wdat;
    for (int b = 0; b < NUM_IRQ; b++) begin
      // A mode flip restarts the bit: edge mode begins empty, level mode tracks s.
      if (mode_d[b] != mode_q[b])
        pending_d[b] = mode_d[b] ? 1'b0 : s[b];
      else if (!mode_q[b])
        pending_d[b] = s[b];
      else if (rise[b] || (wr && sel == REG_SET && wdat[b]))
        pending_d[b] = 1'b1;
      else if (wr && sel == REG_PEND && wdat[b])
        pending_d[b] = 1'b0;
    end
    irq_d = |active;
    for (int b = NUM_IRQ - 1; b >= 0; b--) begin
      if (active[b]) vector_d = {1'b1, 5'(b)};
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prev_q    <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      vector_q  <= '0;
    end else begin
      prev_q    <= s;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      vector_q  <= vector_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    case (sel)
      REG_RAW:  PRDATA[NUM_IRQ-1:0] = s;
      REG_EN:   PRDATA[NUM_IRQ-1:0] = enable_q;
      REG_MODE: PRDATA[NUM_IRQ-1:0] = mode_q;
      REG_PEND: PRDATA[NUM_IRQ-1:0] = pending_q;
      REG_VEC:  PRDATA[5:0]         = vector_q;
      default:  PRDATA = '0;
    endcase
  end

  assign irq_o    = irq_q;
  assign irqb_o   = ~irq_q;
  assign vector_o = vector_q;

endmodule
